// File: rtl/xfunc_pkg.sv
// Shared types and default constants for the xfunc sequencer slice.
package xfunc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } xfunc_state_t;

  localparam int XF_W   = 32;
  localparam int XF_CW  = 5;
  localparam int XF_INC = 2;

endpackage

// File: rtl/xfunc_comb.sv
// Combinational f(x, b) = (x + INC) ^ (x + b); both sums wrap modulo 2^W.
module xfunc_comb
  import xfunc_pkg::*;
#(
  parameter int W   = XF_W,
  parameter int INC = XF_INC
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] b,
  output logic [W-1:0] f
);

  logic [W-1:0] w_sum_inc;
  logic [W-1:0] w_sum_b;

  always_comb begin
    w_sum_inc = x + W'(INC);
    w_sum_b   = x + b;
    f         = w_sum_inc ^ w_sum_b;
  end

endmodule

// File: rtl/xfunc_seq.sv
// Multi-cycle sequencer iterating f(x, b) cnt times on one shared datapath;
// busy stalls the pipeline, done pulses for one cycle before result updates.
module xfunc_seq
  import xfunc_pkg::*;
#(
  parameter int W   = XF_W,
  parameter int CW  = XF_CW,
  parameter int INC = XF_INC
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [CW-1:0] cnt,
  input  logic          flush,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result
);

  xfunc_state_t  r_state;
  xfunc_state_t  w_next;
  logic [W-1:0]  r_x;
  logic [W-1:0]  r_b;
  logic [CW-1:0] r_rem;
  logic [W-1:0]  r_result;
  logic [W-1:0]  w_f;
  logic          w_accept;

  xfunc_comb #(.W(W), .INC(INC)) u_comb (
    .x (r_x),
    .b (r_b),
    .f (w_f)
  );

  // A start coinciding with flush in IDLE is dropped, not deferred.
  assign w_accept = (r_state == IDLE) && start && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_x      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (w_accept) begin
          r_x   <= a;
          r_b   <= b;
          r_rem <= cnt;
        end
        RUN: if (!flush) begin
          r_x   <= w_f;
          r_rem <= r_rem - CW'(1);
        end
        DONE: if (!flush) r_result <= r_x;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (cnt != '0) ? RUN : DONE;
      RUN:     if (flush) w_next = IDLE;
               else if (r_rem == CW'(1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (r_state == RUN) || (r_state == DONE);
    done   = (r_state == DONE);
    result = r_result;
  end

endmodule

// File: doc/xfunc_seq.md
# xfunc_seq

Multi-cycle sequencer that iterates the custom ALU function f(x, b) = (x + 2) ^ (x + b) a programmable number of times on one shared combinational f-datapath. It sits beside the EX-stage ALU. The pipeline issues a start with operands and an iteration count. The block raises busy so the hazard unit stalls, then presents the result with a one-cycle done pulse.

## Interface
- W, default 32: operand/result width.
- CW, default 5: iteration-count width; max iterations 2^CW − 1.
- INC, default 2: constant addend in f.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; the only clock domain is clk.
- start  in  1  request from EX; sampled only in IDLE.
- a  in  W  initial x; sampled with start.
- b  in  W  fixed second operand; sampled with start.
- cnt  in  CW  iteration count; sampled with start.
- flush  in  1  synchronous abort of an in-flight operation.
- busy  out  1  high in RUN and DONE; drives the pipeline stall.
- done  out  1  high exactly in the DONE cycle.
- result  out  W  last completed value; held until the next completion.

## Operation
- Function: f(x, b) = ((x + INC) mod 2^W) XOR ((x + b) mod 2^W). Carries out of bit W−1 are discarded; there is no overflow flag.
- Internal registers: x_r[W], b_r[W], rem_r[CW], state.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 captures x_r←a, b_r←b, rem_r←cnt.
  - If cnt≠0, next state is RUN; if cnt=0, next state is DONE.
  - start=0 stays in IDLE.
- RUN, each edge:
  - x_r←f(x_r, b_r) and rem_r←rem_r−1.
  - If rem_r==1, next state is DONE; otherwise stay in RUN.
- DONE:
  - done=1.
  - result←x_r, registered at the DONE→IDLE edge.
  - Next state is IDLE unconditionally.
- result therefore updates on the edge that leaves DONE. During DONE, result still shows the previous completion. The final value is visible from the first IDLE cycle onward.
- start while busy=1, including the DONE cycle, is ignored and not queued. The pipeline holds start asserted under stall and it is accepted in the first IDLE cycle.
- flush=1 in RUN or DONE:
  - Next state is IDLE; result is not updated; no done pulse follows.
  - flush in IDLE has no effect, and a simultaneous start is dropped.
- Priority: reset > flush > start.

## Timing
- Reset values: state=IDLE, busy=0, done=0, result=0, x_r=0, b_r=0, rem_r=0.
- start accepted at edge T:
  - busy rises after T.
  - done is high in cycle T+cnt+1, i.e. the cycle after cnt RUN cycles.
  - result is valid from cycle T+cnt+2.
  - busy falls in the same cycle.
- cnt=0: one DONE cycle, then result=a.
- Back-to-back: the earliest next accept is the edge ending the first IDLE cycle, so the throughput is one operation per cnt+2 cycles.
- reset asserted mid-RUN: all state returns to reset values at that edge, including result=0.
- busy and done are decoded from state registers only; there is no combinational path from inputs to outputs.

## Structure
- Shared package xfunc_pkg holds:
  - state enum {IDLE, RUN, DONE} with a 2-bit encoding;
  - the default constants W=32, CW=5, INC=2.
- Sub-module xfunc_comb: purely combinational; inputs x and b; output f(x, b); parameters W and INC. The sequencer instantiates it once on x_r/b_r.
- The sequencer body is one FSM, a down-counter and three registers. The DONE→IDLE edge is the only writer of result.

## Test plan
- Reset, then a=0, b=0, cnt=2: done high 3 cycles after the accept edge; result=6 (iterations 0→2→6); busy is high for exactly 3 cycles.
- a=5, b=3, cnt=1: result=15 (7^8). Then a=0xFFFFFFFF, b=1, cnt=1: result=1, which checks wrap-around of both adders.
- a=0x1234, cnt=0: done in the cycle after the accept edge; result=0x1234 thereafter; no RUN cycle occurs.
- start held high continuously with cnt=3: the first op is accepted; start is ignored through RUN/DONE; the second is accepted at the first IDLE edge. done pulses are spaced 5 cycles apart.
- flush on the 2nd RUN cycle of a cnt=4 op: no done pulse; result retains its prior value; busy=0 on the next cycle; a new start is accepted immediately after.
- reset asserted mid-RUN with cnt=31: the next cycle has busy=0, done=0, result=0. A fresh op afterward completes correctly.
